// File: rtl/ahb_master_if.sv
// ahb_master_if: single-beat AHB-Lite master for the edge-detection datapath.
// Reads land on greyscale_data; writes take their data from output buffer 2.
// One transfer at a time: address phase, data phase (with wait states), done pulse.
// Optional macro AHB_HTRANS_EN adds a registered htrans output (NONSEQ in address phase).
module ahb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] mcu_raddr,
    input  logic [ADDR_WIDTH-1:0] mcu_waddr,
    input  logic [DATA_WIDTH-1:0] buffer2_data,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hrdata,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] greyscale_data,
    output logic                  read_complete,
    output logic                  write_complete
`ifdef AHB_HTRANS_EN
    ,
    output logic [1:0]            htrans
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] RDONE = 3'd3;
    localparam logic [2:0] WADDR = 3'd4;
    localparam logic [2:0] WDATA = 3'd5;
    localparam logic [2:0] WDONE = 3'd6;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;

    logic [2:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] haddr_reg, haddr_next;
    logic                  hwrite_reg, hwrite_next;
    logic [DATA_WIDTH-1:0] hwdata_reg, hwdata_next;
    logic [DATA_WIDTH-1:0] grey_reg, grey_next;
    logic                  read_complete_reg;
    logic                  write_complete_reg;
    logic [1:0]            htrans_reg;

    // Next-state and next-value decode for the transfer sequencer.
    always_comb begin
        state_next  = state_reg;
        haddr_next  = haddr_reg;
        hwrite_next = hwrite_reg;
        hwdata_next = hwdata_reg;
        grey_next   = grey_reg;
        case (state_reg)
            IDLE: begin
                if (re) begin
                    // A simultaneous write request is dropped; the read wins.
                    haddr_next  = mcu_raddr;
                    hwrite_next = 1'b0;
                    state_next  = RADDR;
                end else if (we) begin
                    haddr_next  = mcu_waddr;
                    hwrite_next = 1'b1;
                    state_next  = WADDR;
                end else begin
                    hwrite_next = 1'b0;
                end
            end
            RADDR: state_next = RDATA;
            RDATA: begin
                if (hready) begin
                    grey_next  = hrdata;
                    state_next = RDONE;
                end
            end
            RDONE: state_next = IDLE;
            WADDR: begin
                hwdata_next = buffer2_data;
                state_next  = WDATA;
            end
            WDATA: begin
                // Keep following the buffer until the slave accepts the beat.
                if (hready) begin
                    state_next = WDONE;
                end else begin
                    hwdata_next = buffer2_data;
                end
            end
            WDONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and bus-facing registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg          <= IDLE;
            haddr_reg          <= '0;
            hwrite_reg         <= 1'b0;
            hwdata_reg         <= '0;
            grey_reg           <= '0;
            read_complete_reg  <= 1'b0;
            write_complete_reg <= 1'b0;
            htrans_reg         <= HTRANS_IDLE;
        end else begin
            state_reg          <= state_next;
            haddr_reg          <= haddr_next;
            hwrite_reg         <= hwrite_next;
            hwdata_reg         <= hwdata_next;
            grey_reg           <= grey_next;
            // Pulses are registered so they are high exactly while in a done state.
            read_complete_reg  <= (state_next == RDONE);
            write_complete_reg <= (state_next == WDONE);
            htrans_reg         <= ((state_next == RADDR) || (state_next == WADDR))
                                  ? HTRANS_NONSEQ : HTRANS_IDLE;
        end
    end

    assign haddr          = haddr_reg;
    assign hwrite         = hwrite_reg;
    assign hwdata         = hwdata_reg;
    assign greyscale_data = grey_reg;
    assign read_complete  = read_complete_reg;
    assign write_complete = write_complete_reg;

`ifdef AHB_HTRANS_EN
    assign htrans = htrans_reg;
`else
    // Without the transfer-type output the register has no reader.
    logic unused_htrans;
    assign unused_htrans = ^htrans_reg;
`endif

endmodule

// File: tb/tb_ahb_master_if.sv
// Testbench for ahb_master_if: transaction-level expectation model compared every
// cycle, plus hand-computed literal checks on the directed scenarios.
module tb_ahb_master_if;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        re, we, hready;
    logic [31:0] mcu_raddr, mcu_waddr, buffer2_data, hrdata;
    logic [31:0] haddr, hwdata, greyscale_data;
    logic        hwrite, read_complete, write_complete;
`ifdef AHB_HTRANS_EN
    logic [1:0]  htrans;
`endif

    int vectors = 0;
    int miscompares = 0;
    int rc_seen = 0;
    int wc_seen = 0;

    always #5 tb_clk = ~tb_clk;

    ahb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (tb_clk),
        .n_rst          (n_rst),
        .re             (re),
        .we             (we),
        .mcu_raddr      (mcu_raddr),
        .mcu_waddr      (mcu_waddr),
        .buffer2_data   (buffer2_data),
        .hready         (hready),
        .hrdata         (hrdata),
        .haddr          (haddr),
        .hwrite         (hwrite),
        .hwdata         (hwdata),
        .greyscale_data (greyscale_data),
        .read_complete  (read_complete),
        .write_complete (write_complete)
`ifdef AHB_HTRANS_EN
        ,
        .htrans         (htrans)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectation model: tracks the transfer as kind + phase
    // (0 idle, 1 address, 2 data, 3 done).
    int          m_phase = 0;
    bit          m_is_write = 1'b0;
    logic [31:0] m_haddr = '0, m_hwdata = '0, m_grey = '0;
    logic        m_hwrite = 1'b0, m_rc = 1'b0, m_wc = 1'b0;

    always @(posedge tb_clk or negedge n_rst) begin
        if (!n_rst) begin
            m_phase = 0; m_haddr = '0; m_hwrite = 1'b0; m_hwdata = '0;
            m_grey = '0; m_rc = 1'b0; m_wc = 1'b0;
        end else begin
            m_rc = 1'b0;
            m_wc = 1'b0;
            if (m_phase == 0) begin
                if (re) begin
                    m_is_write = 1'b0; m_haddr = mcu_raddr; m_hwrite = 1'b0; m_phase = 1;
                end else if (we) begin
                    m_is_write = 1'b1; m_haddr = mcu_waddr; m_hwrite = 1'b1; m_phase = 1;
                end else begin
                    m_hwrite = 1'b0;
                end
            end else if (m_phase == 1) begin
                if (m_is_write) m_hwdata = buffer2_data;
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (hready) begin
                    if (m_is_write) m_wc = 1'b1;
                    else begin m_rc = 1'b1; m_grey = hrdata; end
                    m_phase = 3;
                end else if (m_is_write) begin
                    m_hwdata = buffer2_data;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge tb_clk) begin
        check("haddr", haddr, m_haddr);
        check("hwrite", {31'd0, hwrite}, {31'd0, m_hwrite});
        check("hwdata", hwdata, m_hwdata);
        check("greyscale_data", greyscale_data, m_grey);
        check("read_complete", {31'd0, read_complete}, {31'd0, m_rc});
        check("write_complete", {31'd0, write_complete}, {31'd0, m_wc});
`ifdef AHB_HTRANS_EN
        check("htrans", {30'd0, htrans}, (m_phase == 1) ? 32'd2 : 32'd0);
`endif
        if (read_complete === 1'b1) rc_seen++;
        if (write_complete === 1'b1) wc_seen++;
    end

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Single write with 'waits' wait states; buffer data varies until the last sampled edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int waits);
        int wc0;
        wc0 = wc_seen;
        we = 1'b1; mcu_waddr = addr; buffer2_data = ~data; hready = 1'b0;
        step();
        check("wr_haddr", haddr, addr);
        check("wr_hwrite", {31'd0, hwrite}, 32'd1);
        we = 1'b0;
        buffer2_data = (waits > 0) ? (data ^ 32'h1) : data;
        step();
        for (int i = 0; i < waits; i++) begin
            buffer2_data = (i == waits - 1) ? data : (data ^ (i + 2));
            step();
        end
        hready = 1'b1; buffer2_data = ~data;
        step();
        check("wr_complete", {31'd0, write_complete}, 32'd1);
        check("wr_hwdata", hwdata, data);
        hready = 1'b0;
        step();
        check("wr_pulse_count", wc_seen - wc0, 1);
    endtask

    // Single read with 'waits' wait states; bus data is garbage until hready.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int waits);
        int rc0;
        rc0 = rc_seen;
        re = 1'b1; mcu_raddr = addr; hrdata = ~data; hready = 1'b0;
        step();
        check("rd_haddr", haddr, addr);
        check("rd_hwrite", {31'd0, hwrite}, 32'd0);
        re = 1'b0;
        step();
        repeat (waits) step();
        hready = 1'b1; hrdata = data;
        step();
        check("rd_complete", {31'd0, read_complete}, 32'd1);
        check("rd_grey", greyscale_data, data);
        hready = 1'b0; hrdata = ~data;
        step();
        check("rd_grey_hold", greyscale_data, data);
        check("rd_pulse_count", rc_seen - rc0, 1);
    endtask

    initial begin
        logic [31:0] pat [4];
        int rc0, wc0;
        pat[0] = 32'hFFFFFFFF; pat[1] = 32'h00000000;
        pat[2] = 32'hAAAAAAAA; pat[3] = 32'h55555555;

        n_rst = 1'b0; re = 1'b0; we = 1'b0; hready = 1'b0;
        mcu_raddr = '0; mcu_waddr = '0; buffer2_data = '0; hrdata = '0;
        #12;
        check("rst_haddr", haddr, 32'd0);
        check("rst_outs", {28'd0, hwrite, read_complete, write_complete, 1'b0}, 32'd0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        step();

        // Basic write and read from the test plan (2 wait states each).
        do_write(32'd2, 32'hAAAAAAAA, 2);
        $display("write addr=2 data=aaaaaaaa done");
        do_read(32'd3, 32'h55555555, 2);
        $display("read addr=3 data=55555555 done");

        // Back-to-back sweep.
        for (int i = 0; i < 4; i++) begin
            do_write(i, pat[i], i);
            $display("sweep write addr=%0d data=%h", i, pat[i]);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(i, pat[i], 3 - i);
            $display("sweep read addr=%0d data=%h", i, pat[i]);
        end

        // Spurious hready during request / address phase.
        rc0 = rc_seen; wc0 = wc_seen;
        hready = 1'b1; re = 1'b1; mcu_raddr = 32'h10; hrdata = 32'h12345678;
        step();
        check("spur_rc", {31'd0, read_complete}, 32'd0);
        check("spur_wc", {31'd0, write_complete}, 32'd0);
        re = 1'b0;
        step();
        check("spur_rc_addr", {31'd0, read_complete}, 32'd0);
        step(); step();
        hready = 1'b0;
        check("spur_pulses", (rc_seen - rc0) * 16 + (wc_seen - wc0), 16);
        $display("spurious hready read done");

        // Simultaneous read and write request: read wins.
        wc0 = wc_seen; rc0 = rc_seen;
        re = 1'b1; we = 1'b1; mcu_raddr = 32'h5; mcu_waddr = 32'h9; hrdata = 32'hC0FFEE00;
        step();
        check("both_hwrite", {31'd0, hwrite}, 32'd0);
        check("both_haddr", haddr, 32'h5);
        re = 1'b0; we = 1'b0;
        step();
        hready = 1'b1;
        step();
        hready = 1'b0;
        step(); step();
        check("both_no_wc", wc_seen - wc0, 0);
        check("both_rc", rc_seen - rc0, 1);
        check("both_grey", greyscale_data, 32'hC0FFEE00);
        $display("simultaneous re/we done");

        // Reset in the data phase of a read.
        rc0 = rc_seen; wc0 = wc_seen;
        re = 1'b1; mcu_raddr = 32'h7; hrdata = 32'h0BADF00D;
        step();
        re = 1'b0;
        step(); step();
        #2 n_rst = 1'b0;
        #1;
        check("arst_haddr", haddr, 32'd0);
        check("arst_grey", greyscale_data, 32'd0);
        check("arst_hwdata", hwdata, 32'd0);
        check("arst_flags", {29'd0, hwrite, read_complete, write_complete}, 32'd0);
        step(); step();
        n_rst = 1'b1;
        hready = 1'b1;
        repeat (3) step();
        hready = 1'b0;
        check("arst_no_pulse", (rc_seen - rc0) + (wc_seen - wc0), 0);
        $display("reset during read data phase done");

        // Recovery after reset.
        do_write(32'h20, 32'h13579BDF, 1);
        do_read(32'h21, 32'h2468ACE0, 0);
        $display("post-reset write/read done");

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_master_if.md
Name: ahb_master_if

Overview:
- Single-beat AHB-Lite bus master for the edge-detection datapath.
- Turns MCU read requests into AHB reads and returns the word on greyscale_data.
- Turns MCU write requests into AHB writes, with data taken from output buffer 2.
- Handles one transfer at a time: address phase, data phase with wait states, then a one-cycle completion pulse.

Parameters:
- ADDR_WIDTH, 32, width of mcu_raddr, mcu_waddr and haddr.
- DATA_WIDTH, 32, width of buffer2_data, hrdata, hwdata and greyscale_data.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset; asynchronous, active-low.
- re  input  1  read request; sampled in IDLE only.
- we  input  1  write request; sampled in IDLE only.
- mcu_raddr  input  ADDR_WIDTH  read address, captured with re.
- mcu_waddr  input  ADDR_WIDTH  write address, captured with we.
- buffer2_data  input  DATA_WIDTH  write data source.
- hready  input  1  AHB slave ready; ends the data phase.
- hrdata  input  DATA_WIDTH  AHB read data.
- haddr  output  ADDR_WIDTH  AHB address (registered).
- hwrite  output  1  1 = write transfer, 0 = read transfer (registered).
- hwdata  output  DATA_WIDTH  AHB write data (registered).
- greyscale_data  output  DATA_WIDTH  last word read from the bus (registered, held).
- read_complete  output  1  one-cycle pulse when a read finishes.
- write_complete  output  1  one-cycle pulse when a write finishes.

Behaviour:
- Reset (async, n_rst=0):
  - state goes to IDLE.
  - haddr, hwrite, hwdata, greyscale_data, read_complete and write_complete all clear to 0.
  - Reset asserted mid-transfer aborts the transfer; no completion pulse is generated.
- States: IDLE, RADDR, RDATA, RDONE, WADDR, WDATA, WDONE.
- IDLE:
  - re=1: load haddr<=mcu_raddr and hwrite<=0, go to RADDR.
  - else we=1: load haddr<=mcu_waddr and hwrite<=1, go to WADDR.
  - re=1 and we=1 together: the read wins, hwrite=0, and the write request is dropped.
  - Neither asserted: stay in IDLE; haddr holds its value, hwrite goes to 0.
- RADDR: go to RDATA unconditionally; hready is ignored in the address phase.
- RDATA:
  - hready=0: stay (wait state).
  - hready=1: greyscale_data<=hrdata, go to RDONE.
- RDONE: read_complete=1 for this cycle only, then go to IDLE.
- WADDR: hwdata<=buffer2_data, go to WDATA unconditionally; hready is ignored.
- WDATA:
  - While hready=0, hwdata keeps tracking buffer2_data every cycle.
  - hready=1: go to WDONE; hwdata holds.
- WDONE: write_complete=1 for this cycle only, then go to IDLE.
- Completion pulses are registered outputs that are high exactly while in RDONE or WDONE.
- Cycle timing:
  - haddr/hwrite are valid 1 cycle after the request edge.
  - Completion comes 1 cycle after the edge where hready is seen high in the data phase.
  - Minimum transfer length is 4 cycles from request to return to IDLE.
- haddr and hwrite hold their values through the data and done states.
- greyscale_data holds its value until the next completed read.
- re/we are ignored outside IDLE; there is no request queueing.

Optional Feature:
- Macro AHB_HTRANS_EN adds an output htrans [1:0], registered.
- htrans = 2'b10 (NONSEQ) while in RADDR/WADDR; 2'b00 (IDLE) in all other states and during reset.
- Without the macro there is no htrans port; the slave decodes transfers from the FSM timing only.

Test Plan:
- Write: we=1, mcu_waddr=2 for one cycle; then buffer2_data=32'hAAAAAAAA, hready=0 for 2 cycles, then hready=1 -> haddr=2 and hwrite=1 after the first edge; hwdata=32'hAAAAAAAA during the data phase; write_complete=1 for exactly one cycle after the hready edge.
- Read: re=1, mcu_raddr=3 for one cycle; hrdata=32'h55555555, hready=1 after 2 wait cycles -> haddr=3 and hwrite=0; greyscale_data=32'h55555555 and read_complete=1 in the cycle after the hready edge; greyscale_data holds afterwards.
- Back-to-back sweep of addresses 0..3 with data FFFFFFFF/00000000/AAAAAAAA/55555555 for both writes and reads -> every field matches per transfer; no spurious completion pulses.
- Spurious hready: after reset, hready=1 with re=1 (or we=1) -> after the first edge both read_complete and write_complete are 0.
- Simultaneous re=1, we=1 from IDLE -> hwrite=0 and haddr=mcu_raddr; only read_complete ever pulses.
- Reset asserted in RDATA with hready=0 -> all outputs 0 immediately; no completion pulse after release.
